// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: DATA_W-bit MSB-first words, per-transfer
// CPOL/CPHA, SCK half-period of CLK_DIV clocks, optional CS hold for bursts.
module spi_master_param #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_start,
    input  logic [1:0]        I_mode,
    input  logic              I_cs_hold,
    input  logic [DATA_W-1:0] I_data_in,
    output logic [DATA_W-1:0] O_data_out,
    output logic              O_done,
    output logic              O_busy,
    input  logic              I_spi_miso,
    output logic              O_spi_sck,
    output logic              O_spi_cs,
    output logic              O_spi_mosi
);
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_FINAL = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_HELD
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [1:0]          mode_q, mode_d;
    logic                hold_q, hold_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                sck_q, sck_d;
    logic                cs_q, cs_d;
    logic                mosi_q, mosi_d;
    logic                div_last;
    logic                accept;
    logic                edge_fire;
    logic                lead_edge;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            edge_q     <= '0;
            mode_q     <= '0;
            hold_q     <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            mode_q     <= mode_d;
            hold_q     <= hold_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        mode_d     = mode_q;
        hold_d     = hold_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        sck_d      = sck_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;

        div_last  = (div_q == DIV_LAST);
        accept    = I_start && ((state_q == ST_IDLE) || (state_q == ST_HELD));
        edge_fire = div_last && ((state_q == ST_SETUP) ||
                                 ((state_q == ST_SHIFT) && (edge_q != EDGE_LAST)));
        // edge_q holds the number of edges already issued, so an even count means the next is leading
        lead_edge = ~edge_q[0];

        if ((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD)) begin
            div_d = div_last ? '0 : div_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cs_d  = 1'b1;
                sck_d = I_mode[1];
            end
            ST_SETUP: begin
                if (div_last) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_last && (edge_q == EDGE_LAST)) begin
                    state_d = ST_HOLD;
                    sck_d   = mode_q[1];
                end
            end
            ST_HOLD: begin
                if (div_last) begin
                    done_d     = 1'b1;
                    data_out_d = rx_q;
                    busy_d     = 1'b0;
                    if (hold_q) begin
                        state_d = ST_HELD;
                    end else begin
                        state_d = ST_IDLE;
                        cs_d    = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (!I_cs_hold) begin
                    state_d = ST_IDLE;
                    cs_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Sample when the edge type differs from CPHA; otherwise this edge moves MOSI.
        if (edge_fire) begin
            sck_d  = ~sck_q;
            edge_d = edge_q + 1'b1;
            if (lead_edge ^ mode_q[0]) begin
                rx_d = {rx_q[DATA_W-2:0], I_spi_miso};
            end else if (mode_q[0]) begin
                mosi_d = tx_q[DATA_W-1];
                tx_d   = tx_q << 1;
            end else if (edge_q != EDGE_FINAL) begin
                mosi_d = tx_q[DATA_W-2];
                tx_d   = tx_q << 1;
            end
        end

        if (accept) begin
            state_d = ST_SETUP;
            mode_d  = I_mode;
            hold_d  = I_cs_hold;
            tx_d    = I_data_in;
            rx_d    = '0;
            div_d   = '0;
            edge_d  = '0;
            busy_d  = 1'b1;
            cs_d    = 1'b0;
            sck_d   = I_mode[1];
            if (!I_mode[0]) begin
                mosi_d = I_data_in[DATA_W-1];
            end
        end
    end

    assign O_data_out = data_out_q;
    assign O_done     = done_q;
    assign O_busy     = busy_q;
    assign O_spi_sck  = sck_q;
    assign O_spi_cs   = cs_q;
    assign O_spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: an 8-bit/div-4 instance driven against an
// edge-counting SPI slave model, plus a 16-bit/div-1 instance in loopback.
`timescale 1ns/1ps
module tb_spi_master_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       cs_hold = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       done, busy, miso, sck, cs, mosi;

    logic        w_start = 1'b0;
    logic [15:0] w_din = '0;
    logic [15:0] w_dout;
    logic        w_done, w_busy, w_sck, w_cs, w_mosi;

    int checks = 0;
    int errors = 0;

    // slave model state
    logic       lb = 1'b1;
    logic [7:0] sl_word = '0;
    logic [7:0] sl_cap = '0;
    logic       sl_cpha = 1'b0;
    logic       sl_prev = 1'b0;
    int         sl_cnt = 0;
    int         sl_rise = 0;
    int         done_cnt = 0;
    int         cs_rise = 0;

    logic       w_prev = 1'b0;
    int         w_cnt = 0;
    time        w_last = 0;
    time        w_dmin = 0;
    time        w_dmax = 0;

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(8), .CLK_DIV(4)) u_dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_start(start), .I_mode(mode),
        .I_cs_hold(cs_hold), .I_data_in(din), .O_data_out(dout), .O_done(done),
        .O_busy(busy), .I_spi_miso(miso), .O_spi_sck(sck), .O_spi_cs(cs),
        .O_spi_mosi(mosi)
    );

    spi_master_param #(.DATA_W(16), .CLK_DIV(1)) u_wide (
        .I_clk(clk), .I_rst_n(rst_n), .I_start(w_start), .I_mode(2'b00),
        .I_cs_hold(1'b0), .I_data_in(w_din), .O_data_out(w_dout), .O_done(w_done),
        .O_busy(w_busy), .I_spi_miso(w_mosi), .O_spi_sck(w_sck), .O_spi_cs(w_cs),
        .O_spi_mosi(w_mosi)
    );

    // SPI slave: counts SCK edges while selected; shifts out on its launch edges, captures MOSI on sample edges
    always @(sck or cs) begin
        if (cs) begin
            sl_cnt = 0;
        end else if (sck !== sl_prev) begin
            sl_cnt = sl_cnt + 1;
            if (sck) sl_rise = sl_rise + 1;
            if (((sl_cnt % 2) == 1) != sl_cpha) sl_cap = {sl_cap[6:0], mosi};
        end
        sl_prev = sck;
    end

    always_comb miso = lb ? mosi : sl_word[7 - ((sl_cnt % 16) / 2)];

    always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;
    always @(posedge cs) cs_rise = cs_rise + 1;

    always @(w_sck or w_cs) begin
        if (w_cs) begin
            w_cnt = 0;
        end else if (w_sck !== w_prev) begin
            if (w_cnt > 0) begin
                if (w_cnt == 1 || ($time - w_last) < w_dmin) w_dmin = $time - w_last;
                if (w_cnt == 1 || ($time - w_last) > w_dmax) w_dmax = $time - w_last;
            end
            w_last = $time;
            w_cnt  = w_cnt + 1;
        end
        w_prev = w_sck;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_mode(input logic [1:0] m);
        mode    = m;
        sl_cpha = m[0];
        repeat (2) @(negedge clk);
    endtask

    // start one word on the narrow DUT; returns at the negedge where O_done is seen (lat=-1 on timeout)
    task automatic run_word(input logic hold, input logic [7:0] tx, output logic [7:0] rx,
                            output int lat);
        cs_hold = hold;
        din     = tx;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        rx = dout;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs, sck, mosi, done, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_pins: got cs,sck,mosi,done,busy=%b required 10000",
                     {cs, sck, mosi, done, busy});
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %h required 00", dout);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_loopback;
        logic [7:0] rx;
        int lat;
        lb = 1'b1;
        set_mode(2'b00);
        sl_rise = 0;
        sl_cap  = '0;
        run_word(1'b0, 8'hA5, rx, lat);
        checks++;
        if (rx !== 8'hA5) begin
            errors++;
            $display("FAIL t1_rx: got %h required a5", rx);
        end
        checks++;
        if (lat !== 72) begin
            errors++;
            $display("FAIL t1_latency: got %0d required 72", lat);
        end
        checks++;
        if (sl_rise !== 8) begin
            errors++;
            $display("FAIL t1_rising_edges: got %0d required 8", sl_rise);
        end
        checks++;
        if (sl_cap !== 8'hA5) begin
            errors++;
            $display("FAIL t1_mosi_stream: got %h required a5", sl_cap);
        end
        checks++;
        if ({cs, busy} !== 2'b10) begin
            errors++;
            $display("FAIL t1_cs_after: got cs,busy=%b required 10", {cs, busy});
        end
    endtask

    task automatic check_word(input string name, input logic [1:0] m, input logic use_lb,
                              input logic [7:0] tx, input logic [7:0] sw);
        logic [7:0] rx;
        logic [7:0] exp_rx;
        int lat;
        lb      = use_lb;
        sl_word = sw;
        set_mode(m);
        checks++;
        if (sck !== m[1]) begin
            errors++;
            $display("FAIL %s_idle_before: got sck=%b required %b", name, sck, m[1]);
        end
        sl_cap = '0;
        run_word(1'b0, tx, rx, lat);
        exp_rx = use_lb ? tx : sw;
        checks++;
        if (rx !== exp_rx) begin
            errors++;
            $display("FAIL %s_rx: mode %0d got %h required %h", name, m, rx, exp_rx);
        end
        checks++;
        if (sl_cap !== tx) begin
            errors++;
            $display("FAIL %s_mosi: mode %0d got %h required %h", name, m, sl_cap, tx);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sck !== m[1] || cs !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_after: got sck=%b cs=%b required sck=%b cs=1", name, sck, cs, m[1]);
        end
    endtask

    task automatic test_modes;
        for (int m = 1; m < 4; m++) check_word("t2", 2'(m), 1'b0, 8'h3C, 8'hC3);
        for (int i = 0; i < 6; i++)
            check_word("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       8'($urandom), 8'($urandom));
    endtask

    task automatic test_burst;
        logic [7:0] rx1, rx2, rx3;
        int lat, d0;
        lb = 1'b1;
        set_mode(2'b00);
        d0 = done_cnt;
        cs_rise = 0;
        run_word(1'b1, 8'h01, rx1, lat);
        run_word(1'b1, 8'h02, rx2, lat);
        checks++;
        if (cs_rise !== 0 || cs !== 1'b0) begin
            errors++;
            $display("FAIL t3_cs_held: got rises=%0d cs=%b required 0 rises cs=0", cs_rise, cs);
        end
        run_word(1'b0, 8'h03, rx3, lat);
        checks++;
        if ({rx1, rx2, rx3} !== 24'h010203) begin
            errors++;
            $display("FAIL t3_rx: got %h required 010203", {rx1, rx2, rx3});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 3) begin
            errors++;
            $display("FAIL t3_done_count: got %0d required 3", done_cnt - d0);
        end
        checks++;
        if (cs !== 1'b1 || cs_rise !== 1) begin
            errors++;
            $display("FAIL t3_cs_end: got cs=%b rises=%0d required cs=1 rises=1", cs, cs_rise);
        end
    endtask

    task automatic test_ignore_start;
        logic [7:0] rx;
        int lat, d0;
        lb = 1'b1;
        set_mode(2'b00);
        d0 = done_cnt;
        cs_hold = 1'b0;
        din     = 8'hA5;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_busy: got %b required 1", busy);
        end
        din   = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        rx = dout;
        checks++;
        if (rx !== 8'hA5 || lat < 0) begin
            errors++;
            $display("FAIL t5_rx: got %h (lat %0d) required a5", rx, lat);
        end
        repeat (100) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL t5_done_count: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rx, tx;
        int lat, d0;
        logic reached;
        lb = 1'b1;
        set_mode(2'b00);
        d0 = done_cnt;
        cs_hold = 1'b0;
        din     = 8'h5A;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (sl_cnt >= 5) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL t6_fifth_edge: got no 5th edge required 5 edges");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs, sck} !== 2'b10) begin
            errors++;
            $display("FAIL t6_async: got cs,sck=%b required 10", {cs, sck});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL t6_no_done: got %0d pulses required 0", done_cnt - d0);
        end
        tx = 8'($urandom);
        set_mode(2'b00);
        run_word(1'b0, tx, rx, lat);
        checks++;
        if (rx !== tx || lat !== 72) begin
            errors++;
            $display("FAIL t6_after: got rx=%h lat=%0d required rx=%h lat=72", rx, lat, tx);
        end
    endtask

    task automatic test_wide;
        int lat;
        w_din   = 16'hBEEF;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (w_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (w_dout !== 16'hBEEF) begin
            errors++;
            $display("FAIL t4_rx: got %h required beef", w_dout);
        end
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL t4_latency: got %0d required 34", lat);
        end
        checks++;
        if (w_cnt !== 32 && !(w_cs === 1'b1 && w_cnt === 0)) begin
            errors++;
            $display("FAIL t4_edges: got %0d required 32", w_cnt);
        end
        checks++;
        if (w_dmin !== 10 || w_dmax !== 10) begin
            errors++;
            $display("FAIL t4_half_period: got min %0t max %0t required 10", w_dmin, w_dmax);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_modes();
        test_burst();
        test_ignore_start();
        test_wide();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
